// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide, one bit per clock.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [3:0]       alu_control,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CMAX = SW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state_reg, state_next;
  logic [SW-1:0]    count_reg;
  logic [WIDTH-1:0] opa_reg;   // multiplicand or divisor
  logic [WIDTH-1:0] hi_reg;    // partial product high half or partial remainder
  logic [WIDTH-1:0] lo_reg;    // multiplier/product low half or dividend/quotient

  logic             accept, last_iter, op_multi;
  logic [WIDTH-1:0] sum, diff, sc_result;
  logic             sc_ovf;
  logic [SW-1:0]    shamt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state and handshake
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    accept     = 1'b0;
    op_multi   = (alu_control == OP_MUL) || (alu_control == OP_DIV);
    last_iter  = (count_reg == CMAX);
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept = 1'b1;
          if (alu_control == OP_MUL)      state_next = MUL;
          else if (alu_control == OP_DIV) state_next = DIV;
        end
      end
      MUL, DIV: if (last_iter) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Single-cycle operations, evaluated straight from the live inputs
  always_comb begin
    sum       = input1 + input2;
    diff      = input1 - input2;
    shamt     = input1[SW-1:0];
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (alu_control)
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_AND: sc_result = input1 & input2;
      OP_OR:  sc_result = input1 | input2;
      OP_NOR: sc_result = ~(input1 | input2);
      OP_SLL: sc_result = input2 << shamt;
      OP_SRL: sc_result = input2 >> shamt;
      OP_SRA: sc_result = $unsigned($signed(input2) >>> shamt);
      OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      default: sc_result = '0;
    endcase
  end

  // One iteration step of the multiplier or divider
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opa_reg} : {(WIDTH+1){1'b0}});
    div_trial = {hi_reg, lo_reg[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opa_reg});
    div_sub   = div_trial[WIDTH-1:0] - opa_reg;
    if (state_reg == DIV) begin
      iter_hi = div_ge ? div_sub : div_trial[WIDTH-1:0];
      iter_lo = {lo_reg[WIDTH-2:0], div_ge};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  // Datapath and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      opa_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      done          <= 1'b0;
      alu_result    <= '0;
      alu_result_hi <= '0;
      zero          <= 1'b0;
      overflow      <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        count_reg <= '0;
        hi_reg    <= '0;
        if (alu_control == OP_DIV) begin
          opa_reg <= input2;
          lo_reg  <= input1;
        end else begin
          opa_reg <= input1;
          lo_reg  <= input2;
        end
        if (!op_multi) begin
          done          <= 1'b1;
          alu_result    <= sc_result;
          alu_result_hi <= '0;
          zero          <= (sc_result == '0);
          overflow      <= sc_ovf;
          div_by_zero   <= 1'b0;
        end
      end else if (state_reg != IDLE) begin
        hi_reg    <= iter_hi;
        lo_reg    <= iter_lo;
        count_reg <= count_reg + SW'(1);
        // A zero divisor makes every trial succeed, so the quotient fills with
        // ones and the dividend shifts whole into the remainder.
        if (last_iter) begin
          done          <= 1'b1;
          alu_result    <= iter_lo;
          alu_result_hi <= iter_hi;
          zero          <= (iter_lo == '0);
          overflow      <= 1'b0;
          div_by_zero   <= (state_reg == DIV) && (opa_reg == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: arithmetic reference model with a
// scheduled-completion queue, checked every cycle, plus literal spot checks.
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] input1 = '0;
  logic [W-1:0] input2 = '0;
  logic [3:0]   alu_control = '0;
  logic         ready, done, zero, overflow, div_by_zero;
  logic [W-1:0] alu_result, alu_result_hi;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .input1(input1), .input2(input2),
    .alu_control(alu_control), .ready(ready), .done(done), .alu_result(alu_result),
    .alu_result_hi(alu_result_hi), .zero(zero), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic         z, o, d;
    int           due;
    bit           multi;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int total = 0;
  int passed = 0;
  logic [W-1:0] held_r = '0, held_hi = '0;
  logic         held_z = 1'b0, held_o = 1'b0, held_d = 1'b0;
  logic [W-1:0] last_r = '0, last_hi = '0;
  logic         last_z = 1'b0, last_o = 1'b0, last_d = 1'b0;
  int last_done = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain integer arithmetic on the operands
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint s;
    logic [63:0] p;
    int sh;
    e.r = '0; e.hi = '0; e.o = 1'b0; e.d = 1'b0; e.multi = 1'b0; e.due = 0;
    sh = int'(a[4:0]);
    case (c)
      4'b0010: begin
        e.r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.o = (s != longint'($signed(e.r)));
      end
      4'b0110: begin
        e.r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.o = (s != longint'($signed(e.r)));
      end
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b1100: e.r = ~(a | b);
      4'b1001: e.r = b << sh;
      4'b1010: e.r = b >> sh;
      4'b1011: e.r = $unsigned($signed(b) >>> sh);
      4'b0111: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: begin
        p = 64'(a) * 64'(b);
        e.r = p[31:0]; e.hi = p[63:32]; e.multi = 1'b1;
      end
      4'b0100: begin
        e.multi = 1'b1;
        if (b == '0) begin e.r = '1; e.hi = a; e.d = 1'b1; end
        else begin e.r = a / b; e.hi = a % b; end
      end
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Per-cycle compare against the model schedule
  always @(negedge clk) begin
    bit due_now, busy;
    if (!rst_n) begin
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(alu_result), 64'd0);
      chk("rst_result_hi", 64'(alu_result_hi), 64'd0);
      chk("rst_flags", {61'd0, zero, overflow, div_by_zero}, 64'd0);
    end else begin
      due_now = (q.size() > 0) && (q[0].due == cyc);
      busy = 1'b0;
      foreach (q[i]) if (q[i].multi && q[i].due > cyc) busy = 1'b1;
      chk("ready", 64'(ready), 64'(!busy));
      chk("done", 64'(done), 64'(due_now));
      if (due_now) begin
        held_r = q[0].r; held_hi = q[0].hi; held_z = q[0].z; held_o = q[0].o; held_d = q[0].d;
        last_r = alu_result; last_hi = alu_result_hi;
        last_z = zero; last_o = overflow; last_d = div_by_zero;
        last_done = cyc;
        void'(q.pop_front());
      end
      chk("alu_result", 64'(alu_result), 64'(held_r));
      chk("alu_result_hi", 64'(alu_result_hi), 64'(held_hi));
      chk("zero", 64'(zero), 64'(held_z));
      chk("overflow", 64'(overflow), 64'(held_o));
      chk("div_by_zero", 64'(div_by_zero), 64'(held_d));
    end
  end

  task automatic setup(input bit st, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    start = st; alu_control = c; input1 = a; input2 = b;
    if (st && ready && rst_n) begin
      e = model(c, a, b);
      e.due = cyc + 1 + (e.multi ? W : 0);
      q.push_back(e);
      last_acc = cyc + 1;
      $display("issue ctl=%b a=0x%h b=0x%h -> expect r=0x%h hi=0x%h due=%0d", c, a, b, e.r, e.hi, e.due);
    end
  endtask

  task automatic drive(input bit st, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); #1;
    setup(st, c, a, b);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'b0011, W'($urandom), W'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 100) begin idle(1); n++; end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  logic [3:0]   v_c  [12] = '{4'b0010, 4'b0110, 4'b0111, 4'b1011, 4'b0000, 4'b0001,
                              4'b1100, 4'b1001, 4'b1010, 4'b0110, 4'b1111, 4'b0111};
  logic [W-1:0] v_a  [12] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd4, 32'hF0F0F0F0, 32'h0000FFFF,
                              32'h0, 32'h24, 32'd31, 32'h80000000, 32'd5, 32'd1};
  logic [W-1:0] v_b  [12] = '{32'd1, 32'd5, 32'd1, 32'h80000000, 32'h0FF00FF0, 32'h12340000,
                              32'h0, 32'd1, 32'h80000000, 32'd1, 32'd5, 32'hFFFFFFFF};
  logic [W-1:0] v_r  [12] = '{32'h80000000, 32'h0, 32'h1, 32'hF8000000, 32'h00F000F0, 32'h1234FFFF,
                              32'hFFFFFFFF, 32'h10, 32'h1, 32'h7FFFFFFF, 32'h0, 32'h0};
  logic [1:0]   v_zo [12] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10};

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(1'b1, v_c[i], v_a[i], v_b[i]);
      wait_idle();
      chk($sformatf("vec%0d_result", i), 64'(last_r), 64'(v_r[i]));
      chk($sformatf("vec%0d_zero_ovf", i), {62'd0, last_z, last_o}, 64'(v_zo[i]));
      chk($sformatf("vec%0d_latency", i), 64'(last_done - last_acc), 64'd0);
      $display("vec%0d ctl=%b result=0x%h zero=%b ovf=%b", i, v_c[i], last_r, last_z, last_o);
    end

    // Multiply with a start pulse and changing operands mid-flight
    drive(1'b1, 4'b0011, 32'hFFFFFFFF, 32'd2);
    idle(5);
    drive(1'b1, 4'b0010, 32'd3, 32'd4);
    wait_idle();
    chk("mul_hi", 64'(last_hi), 64'h1);
    chk("mul_lo", 64'(last_r), 64'hFFFFFFFE);
    chk("mul_latency", 64'(last_done - last_acc), 64'd32);
    $display("mul hi=0x%h lo=0x%h", last_hi, last_r);

    drive(1'b1, 4'b0100, 32'd100, 32'd7);
    wait_idle();
    chk("div_q", 64'(last_r), 64'd14);
    chk("div_r", 64'(last_hi), 64'd2);
    chk("div_dbz_clear", 64'(last_d), 64'd0);
    $display("div 100/7 q=%0d r=%0d", last_r, last_hi);

    drive(1'b1, 4'b0100, 32'd9, 32'd0);
    wait_idle();
    chk("div0_q", 64'(last_r), 64'hFFFFFFFF);
    chk("div0_r", 64'(last_hi), 64'd9);
    chk("div0_flag", 64'(last_d), 64'd1);
    $display("div 9/0 q=0x%h r=%0d dbz=%b", last_r, last_hi, last_d);

    // Reset 10 cycles into a multiply
    drive(1'b1, 4'b0011, 32'd3, 32'd5);
    idle(10);
    @(negedge clk); #1;
    rst_n = 1'b0; start = 1'b0;
    q.delete();
    held_r = '0; held_hi = '0; held_z = 1'b0; held_o = 1'b0; held_d = 1'b0;
    #1;
    chk("async_rst_result_hi", 64'(alu_result_hi), 64'd0);
    chk("async_rst_flags", {61'd0, zero, overflow, div_by_zero}, 64'd0);
    chk("async_rst_ready", 64'(ready), 64'd1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    setup(1'b1, 4'b0010, 32'd1, 32'd1);
    wait_idle();
    chk("post_rst_add", 64'(last_r), 64'd2);
    $display("after reset add 1+1 = %0d", last_r);
    idle(40);

    // Back-to-back: mul start lands in the add's done cycle
    drive(1'b1, 4'b0010, 32'd10, 32'd20);
    drive(1'b1, 4'b0011, 32'd3, 32'd7);
    wait_idle();
    chk("b2b_mul_lo", 64'(last_r), 64'd21);
    chk("b2b_mul_hi", 64'(last_hi), 64'd0);
    $display("back-to-back mul result=%0d", last_r);

    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
